// File: rtl/wb_commit.sv
// wb_commit: in-order writeback/commit buffer with tag-based result capture,
// dual retire per cycle, and commit-time taken-branch recovery.

package wb_commit_pkg;

  localparam int unsigned EX_TAG_W = 8;

  typedef struct packed {
    logic                is_valid;
    logic [EX_TAG_W-1:0] tag;
    logic [31:0]         result;
    logic                is_branch_established;
    logic [31:0]         jumped_to;
  } ex_result;

endpackage

module wb_commit
  import wb_commit_pkg::*;
#(
  parameter int unsigned BUF_SIZE_LOG = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            alloc_valid,
  input  logic [4:0]            alloc_rd [2],
  output logic                  alloc_ready,
  output logic [BUF_SIZE_LOG:0] alloc_tag [2],
  input  ex_result              results [2],
  output logic [1:0]            commit_valid,
  output logic [4:0]            commit_rd [2],
  output logic [31:0]           commit_data [2],
  output logic                  redirect,
  output logic [31:0]           redirect_pc,
  output logic [BUF_SIZE_LOG:0] count
);

  localparam int unsigned N = 1 << BUF_SIZE_LOG;

  typedef logic [BUF_SIZE_LOG:0]   ptr_t;
  typedef logic [BUF_SIZE_LOG-1:0] idx_t;

  // Pointers and per-entry state
  ptr_t        head_q, head_d;
  ptr_t        tail_q, tail_d;
  logic [N-1:0] busy_q, busy_d;
  logic [N-1:0] done_q, done_d;
  logic [N-1:0] phase_q, phase_d;
  logic [N-1:0] br_q, br_d;
  logic [4:0]  rd_q [N];
  logic [4:0]  rd_d [N];
  logic [31:0] data_q [N];
  logic [31:0] data_d [N];
  logic [31:0] target_q [N];
  logic [31:0] target_d [N];

  // Registered commit/redirect outputs
  logic [1:0]  commit_valid_q, commit_valid_d;
  logic [4:0]  commit_rd_q [2];
  logic [4:0]  commit_rd_d [2];
  logic [31:0] commit_data_q [2];
  logic [31:0] commit_data_d [2];
  logic        redirect_q, redirect_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;

  // Combinational helpers
  ptr_t occ;
  logic ready_w;
  ptr_t tag0, tag1;
  ptr_t n_acc;
  idx_t hidx, h1idx;
  logic c0, c1, flush;

  // Upper tag bits beyond this buffer's pointer width carry no information here
  logic unused_ok;
  assign unused_ok = ^{results[0].tag[EX_TAG_W-1:BUF_SIZE_LOG+1],
                       results[1].tag[EX_TAG_W-1:BUF_SIZE_LOG+1]};

  // Occupancy, allocation readiness and tag assignment
  always_comb begin
    occ     = tail_q - head_q;
    ready_w = (occ <= ptr_t'(N - 2));
    tag0    = tail_q;
    tag1    = tail_q + ptr_t'(alloc_valid[0]);
    n_acc   = ready_w ? (ptr_t'(alloc_valid[0]) + ptr_t'(alloc_valid[1])) : '0;
  end

  // Retire decision from registered entry state at head
  always_comb begin
    hidx  = head_q[BUF_SIZE_LOG-1:0];
    h1idx = hidx + idx_t'(1);
    c0    = busy_q[hidx] & done_q[hidx];
    c1    = c0 & ~br_q[hidx] & busy_q[h1idx] & done_q[h1idx];
    flush = c0 & br_q[hidx];
  end

  // Next entry state: writeback, retire, allocate; a flush overrides all
  always_comb begin
    head_d   = head_q;
    tail_d   = tail_q;
    busy_d   = busy_q;
    done_d   = done_q;
    phase_d  = phase_q;
    br_d     = br_q;
    rd_d     = rd_q;
    data_d   = data_q;
    target_d = target_q;

    // slot 1 is applied last so it wins a same-entry collision
    for (int unsigned i = 0; i < 2; i++) begin
      if (results[i].is_valid &&
          busy_q[results[i].tag[BUF_SIZE_LOG-1:0]] &&
          (phase_q[results[i].tag[BUF_SIZE_LOG-1:0]] == results[i].tag[BUF_SIZE_LOG])) begin
        done_d[results[i].tag[BUF_SIZE_LOG-1:0]]   = 1'b1;
        data_d[results[i].tag[BUF_SIZE_LOG-1:0]]   = results[i].result;
        br_d[results[i].tag[BUF_SIZE_LOG-1:0]]     = results[i].is_branch_established;
        target_d[results[i].tag[BUF_SIZE_LOG-1:0]] = results[i].jumped_to;
      end
    end

    if (c0) busy_d[hidx]  = 1'b0;
    if (c1) busy_d[h1idx] = 1'b0;
    head_d = head_q + ptr_t'(c0) + ptr_t'(c1);

    if (ready_w && alloc_valid[0]) begin
      busy_d[tag0[BUF_SIZE_LOG-1:0]]  = 1'b1;
      done_d[tag0[BUF_SIZE_LOG-1:0]]  = 1'b0;
      phase_d[tag0[BUF_SIZE_LOG-1:0]] = tag0[BUF_SIZE_LOG];
      rd_d[tag0[BUF_SIZE_LOG-1:0]]    = alloc_rd[0];
    end
    if (ready_w && alloc_valid[1]) begin
      busy_d[tag1[BUF_SIZE_LOG-1:0]]  = 1'b1;
      done_d[tag1[BUF_SIZE_LOG-1:0]]  = 1'b0;
      phase_d[tag1[BUF_SIZE_LOG-1:0]] = tag1[BUF_SIZE_LOG];
      rd_d[tag1[BUF_SIZE_LOG-1:0]]    = alloc_rd[1];
    end
    tail_d = tail_q + n_acc;

    if (flush) begin
      busy_d = '0;
      done_d = '0;
      head_d = head_q + ptr_t'(1);
      tail_d = head_q + ptr_t'(1);
    end
  end

  // Next registered commit strobes, retired values and redirect pulse
  always_comb begin
    commit_valid_d   = {c1, c0};
    commit_rd_d[0]   = c0 ? rd_q[hidx]    : '0;
    commit_rd_d[1]   = c1 ? rd_q[h1idx]   : '0;
    commit_data_d[0] = c0 ? data_q[hidx]  : '0;
    commit_data_d[1] = c1 ? data_q[h1idx] : '0;
    redirect_d       = flush;
    redirect_pc_d    = flush ? target_q[hidx] : '0;
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q         <= '0;
      tail_q         <= '0;
      busy_q         <= '0;
      done_q         <= '0;
      phase_q        <= '0;
      br_q           <= '0;
      rd_q           <= '{default: '0};
      data_q         <= '{default: '0};
      target_q       <= '{default: '0};
      commit_valid_q <= '0;
      commit_rd_q    <= '{default: '0};
      commit_data_q  <= '{default: '0};
      redirect_q     <= 1'b0;
      redirect_pc_q  <= '0;
    end else begin
      head_q         <= head_d;
      tail_q         <= tail_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      phase_q        <= phase_d;
      br_q           <= br_d;
      rd_q           <= rd_d;
      data_q         <= data_d;
      target_q       <= target_d;
      commit_valid_q <= commit_valid_d;
      commit_rd_q    <= commit_rd_d;
      commit_data_q  <= commit_data_d;
      redirect_q     <= redirect_d;
      redirect_pc_q  <= redirect_pc_d;
    end
  end

  assign alloc_ready  = ready_w;
  assign alloc_tag[0] = tag0;
  assign alloc_tag[1] = tag1;
  assign count        = occ;
  assign commit_valid = commit_valid_q;
  assign commit_rd    = commit_rd_q;
  assign commit_data  = commit_data_q;
  assign redirect     = redirect_q;
  assign redirect_pc  = redirect_pc_q;

endmodule

// File: tb/tb_wb_commit.sv
// Directed bench for wb_commit: reset, out-of-order retire, full, wrap-stale
// tag, branch recovery, same-tag collision, alloc+commit overlap, mid-run reset.

module tb_wb_commit;
  import wb_commit_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [1:0]  alloc_valid;
  logic [4:0]  alloc_rd [2];
  logic        alloc_ready;
  logic [3:0]  alloc_tag [2];
  ex_result    results [2];
  logic [1:0]  commit_valid;
  logic [4:0]  commit_rd [2];
  logic [31:0] commit_data [2];
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [3:0]  count;

  int checks = 0;
  int failures = 0;

  wb_commit #(.BUF_SIZE_LOG(3)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .alloc_valid  (alloc_valid),
    .alloc_rd     (alloc_rd),
    .alloc_ready  (alloc_ready),
    .alloc_tag    (alloc_tag),
    .results      (results),
    .commit_valid (commit_valid),
    .commit_rd    (commit_rd),
    .commit_data  (commit_data),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .count        (count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alloc_valid = '0;
    alloc_rd[0] = '0;
    alloc_rd[1] = '0;
    results[0]  = '0;
    results[1]  = '0;
  endtask

  task automatic drive_alloc(input logic [1:0] v, input logic [4:0] r0, input logic [4:0] r1);
    alloc_valid = v;
    alloc_rd[0] = r0;
    alloc_rd[1] = r1;
  endtask

  task automatic drive_wb(input int unsigned s, input logic [3:0] tag, input logic [31:0] d,
                          input logic br, input logic [31:0] tgt);
    results[s]                       = '0;
    results[s].is_valid              = 1'b1;
    results[s].tag                   = {4'b0000, tag};
    results[s].result                = d;
    results[s].is_branch_established = br;
    results[s].jumped_to             = tgt;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    #12;
    checks++; if (count !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (alloc_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", alloc_ready); end
    checks++; if (commit_valid !== 2'b00) begin failures++; $display("FAIL reset_cv got=%b exp=00", commit_valid); end
    checks++; if (redirect !== 1'b0) begin failures++; $display("FAIL reset_redirect got=%b exp=0", redirect); end
    checks++; if (redirect_pc !== 32'h0) begin failures++; $display("FAIL reset_rpc got=%h exp=0", redirect_pc); end
    checks++; if (commit_data[0] !== 32'h0 || commit_rd[0] !== 5'd0) begin failures++; $display("FAIL reset_cdata got=%h/%0d exp=0/0", commit_data[0], commit_rd[0]); end
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_basic_ooo();
    drive_alloc(2'b11, 5'd1, 5'd2);
    #1;
    checks++; if (alloc_tag[0] !== 4'd0 || alloc_tag[1] !== 4'd1) begin failures++; $display("FAIL basic_tags got=%0d,%0d exp=0,1", alloc_tag[0], alloc_tag[1]); end
    tick(); idle();
    checks++; if (count !== 4'd2) begin failures++; $display("FAIL basic_count2 got=%0d exp=2", count); end
    drive_wb(0, 4'd1, 32'hB, 1'b0, 32'h0);
    tick(); idle();
    checks++; if (commit_valid !== 2'b00) begin failures++; $display("FAIL basic_hold1 got=%b exp=00", commit_valid); end
    drive_wb(0, 4'd0, 32'hA, 1'b0, 32'h0);
    tick(); idle();
    checks++; if (commit_valid !== 2'b00) begin failures++; $display("FAIL basic_hold2 got=%b exp=00", commit_valid); end
    tick();
    checks++; if (commit_valid !== 2'b11) begin failures++; $display("FAIL basic_cv got=%b exp=11", commit_valid); end
    checks++; if (commit_rd[0] !== 5'd1 || commit_rd[1] !== 5'd2) begin failures++; $display("FAIL basic_rd got=%0d,%0d exp=1,2", commit_rd[0], commit_rd[1]); end
    checks++; if (commit_data[0] !== 32'hA || commit_data[1] !== 32'hB) begin failures++; $display("FAIL basic_data got=%h,%h exp=a,b", commit_data[0], commit_data[1]); end
    checks++; if (count !== 4'd0) begin failures++; $display("FAIL basic_count0 got=%0d exp=0", count); end
    tick();
    checks++; if (commit_valid !== 2'b00) begin failures++; $display("FAIL basic_pulse got=%b exp=00", commit_valid); end
    // idle slot 0 must not consume a tag
    drive_alloc(2'b10, 5'd0, 5'd9);
    #1;
    checks++; if (alloc_tag[1] !== 4'd2) begin failures++; $display("FAIL basic_slot1_tag got=%0d exp=2", alloc_tag[1]); end
    idle();
  endtask

  task automatic test_full();
    logic [3:0] exp_cnt;
    logic       exp_rdy;
    for (int k = 0; k < 4; k++) begin
      drive_alloc(2'b11, 5'(10 + 2 * k), 5'(11 + 2 * k));
      if (k == 3) begin
        #1;
        checks++; if (alloc_tag[0] !== 4'h8 || alloc_tag[1] !== 4'h9) begin failures++; $display("FAIL full_wraptag got=%h,%h exp=8,9", alloc_tag[0], alloc_tag[1]); end
      end
      tick(); idle();
      exp_cnt = 4'(2 * (k + 1));
      exp_rdy = (k < 3);
      checks++; if (count !== exp_cnt) begin failures++; $display("FAIL full_count%0d got=%0d exp=%0d", k, count, exp_cnt); end
      checks++; if (alloc_ready !== exp_rdy) begin failures++; $display("FAIL full_ready%0d got=%b exp=%b", k, alloc_ready, exp_rdy); end
    end
    drive_alloc(2'b11, 5'd30, 5'd31);
    drive_wb(0, 4'd2, 32'h22, 1'b0, 32'h0);
    drive_wb(1, 4'd3, 32'h33, 1'b0, 32'h0);
    tick(); idle();
    checks++; if (count !== 4'd8) begin failures++; $display("FAIL full_ignored got=%0d exp=8", count); end
    tick();
    checks++; if (commit_valid !== 2'b11) begin failures++; $display("FAIL full_cv got=%b exp=11", commit_valid); end
    checks++; if (commit_data[0] !== 32'h22 || commit_data[1] !== 32'h33) begin failures++; $display("FAIL full_data got=%h,%h exp=22,33", commit_data[0], commit_data[1]); end
    checks++; if (commit_rd[0] !== 5'd10 || commit_rd[1] !== 5'd11) begin failures++; $display("FAIL full_rd got=%0d,%0d exp=10,11", commit_rd[0], commit_rd[1]); end
    checks++; if (count !== 4'd6 || alloc_ready !== 1'b1) begin failures++; $display("FAIL full_after got=%0d/%b exp=6/1", count, alloc_ready); end
  endtask

  task automatic test_stale_wrap();
    drive_alloc(2'b01, 5'd20, 5'd0);
    #1;
    checks++; if (alloc_tag[0] !== 4'hA) begin failures++; $display("FAIL stale_tag got=%h exp=a", alloc_tag[0]); end
    drive_wb(0, 4'd4, 32'h44, 1'b0, 32'h0);
    drive_wb(1, 4'd5, 32'h55, 1'b0, 32'h0);
    tick(); idle();
    checks++; if (count !== 4'd7) begin failures++; $display("FAIL stale_count7 got=%0d exp=7", count); end
    drive_wb(0, 4'd6, 32'h66, 1'b0, 32'h0);
    drive_wb(1, 4'd7, 32'h77, 1'b0, 32'h0);
    tick(); idle();
    checks++; if (commit_valid !== 2'b11 || commit_data[0] !== 32'h44 || commit_data[1] !== 32'h55 || count !== 4'd5) begin failures++; $display("FAIL stale_c45 got=%b %h %h %0d exp=11 44 55 5", commit_valid, commit_data[0], commit_data[1], count); end
    drive_wb(0, 4'd8, 32'h88, 1'b0, 32'h0);
    drive_wb(1, 4'd9, 32'h99, 1'b0, 32'h0);
    tick(); idle();
    checks++; if (commit_valid !== 2'b11 || commit_data[0] !== 32'h66 || commit_data[1] !== 32'h77 || count !== 4'd3) begin failures++; $display("FAIL stale_c67 got=%b %h %h %0d exp=11 66 77 3", commit_valid, commit_data[0], commit_data[1], count); end
    drive_wb(0, 4'h2, 32'hDEAD, 1'b0, 32'h0);
    tick(); idle();
    checks++; if (commit_valid !== 2'b11 || commit_rd[0] !== 5'd16 || commit_rd[1] !== 5'd17 || commit_data[1] !== 32'h99 || count !== 4'd1) begin failures++; $display("FAIL stale_c89 got=%b %0d %0d %h %0d exp=11 16 17 99 1", commit_valid, commit_rd[0], commit_rd[1], commit_data[1], count); end
    tick();
    checks++; if (commit_valid !== 2'b00) begin failures++; $display("FAIL stale_dropped1 got=%b exp=00", commit_valid); end
    tick();
    checks++; if (commit_valid !== 2'b00 || count !== 4'd1) begin failures++; $display("FAIL stale_dropped2 got=%b/%0d exp=00/1", commit_valid, count); end
    drive_wb(0, 4'hA, 32'hAA, 1'b0, 32'h0);
    tick(); idle();
    tick();
    checks++; if (commit_valid !== 2'b01 || commit_rd[0] !== 5'd20 || commit_data[0] !== 32'hAA || count !== 4'd0) begin failures++; $display("FAIL stale_good got=%b %0d %h %0d exp=01 20 aa 0", commit_valid, commit_rd[0], commit_data[0], count); end
  endtask

  task automatic test_branch();
    drive_alloc(2'b11, 5'd3, 5'd4);
    #1;
    checks++; if (alloc_tag[0] !== 4'hB || alloc_tag[1] !== 4'hC) begin failures++; $display("FAIL br_tags got=%h,%h exp=b,c", alloc_tag[0], alloc_tag[1]); end
    tick();
    drive_alloc(2'b01, 5'd5, 5'd0);
    tick(); idle();
    checks++; if (count !== 4'd3) begin failures++; $display("FAIL br_count3 got=%0d exp=3", count); end
    drive_wb(0, 4'hC, 32'h2, 1'b0, 32'h0);
    drive_wb(1, 4'hD, 32'h3, 1'b0, 32'h0);
    tick(); idle();
    drive_wb(0, 4'hB, 32'h1, 1'b1, 32'h100);
    tick(); idle();
    checks++; if (commit_valid !== 2'b00) begin failures++; $display("FAIL br_hold got=%b exp=00", commit_valid); end
    drive_alloc(2'b01, 5'd9, 5'd0);
    #1;
    checks++; if (alloc_tag[0] !== 4'hE) begin failures++; $display("FAIL br_flushtag got=%h exp=e", alloc_tag[0]); end
    tick(); idle();
    checks++; if (commit_valid !== 2'b01 || commit_rd[0] !== 5'd3 || commit_data[0] !== 32'h1) begin failures++; $display("FAIL br_commit got=%b %0d %h exp=01 3 1", commit_valid, commit_rd[0], commit_data[0]); end
    checks++; if (redirect !== 1'b1 || redirect_pc !== 32'h100) begin failures++; $display("FAIL br_redirect got=%b %h exp=1 100", redirect, redirect_pc); end
    checks++; if (count !== 4'd0) begin failures++; $display("FAIL br_count0 got=%0d exp=0", count); end
    tick();
    checks++; if (redirect !== 1'b0 || commit_valid !== 2'b00 || count !== 4'd0) begin failures++; $display("FAIL br_after got=%b %b %0d exp=0 00 0", redirect, commit_valid, count); end
    tick();
    checks++; if (commit_valid !== 2'b00) begin failures++; $display("FAIL br_noyoung got=%b exp=00", commit_valid); end
    drive_alloc(2'b01, 5'd6, 5'd0);
    #1;
    checks++; if (alloc_tag[0] !== 4'hC) begin failures++; $display("FAIL br_reusetag got=%h exp=c", alloc_tag[0]); end
    tick(); idle();
    checks++; if (count !== 4'd1) begin failures++; $display("FAIL br_realloc got=%0d exp=1", count); end
    tick();
    checks++; if (commit_valid !== 2'b00) begin failures++; $display("FAIL br_freshnotdone got=%b exp=00", commit_valid); end
    drive_wb(0, 4'hC, 32'h77, 1'b0, 32'h0);
    tick(); idle();
    tick();
    checks++; if (commit_valid !== 2'b01 || commit_rd[0] !== 5'd6 || commit_data[0] !== 32'h77) begin failures++; $display("FAIL br_newcommit got=%b %0d %h exp=01 6 77", commit_valid, commit_rd[0], commit_data[0]); end
  endtask

  task automatic test_collision_back_to_back();
    drive_alloc(2'b01, 5'd7, 5'd0);
    #1;
    checks++; if (alloc_tag[0] !== 4'hD) begin failures++; $display("FAIL col_tag got=%h exp=d", alloc_tag[0]); end
    tick(); idle();
    drive_wb(0, 4'hD, 32'h1, 1'b0, 32'h0);
    drive_wb(1, 4'hD, 32'h2, 1'b0, 32'h0);
    tick(); idle();
    drive_alloc(2'b11, 5'd8, 5'd9);
    #1;
    checks++; if (alloc_tag[0] !== 4'hE || alloc_tag[1] !== 4'hF) begin failures++; $display("FAIL col_tags got=%h,%h exp=e,f", alloc_tag[0], alloc_tag[1]); end
    tick(); idle();
    checks++; if (commit_valid !== 2'b01 || commit_rd[0] !== 5'd7 || commit_data[0] !== 32'h2) begin failures++; $display("FAIL col_commit got=%b %0d %h exp=01 7 2", commit_valid, commit_rd[0], commit_data[0]); end
    checks++; if (count !== 4'd2) begin failures++; $display("FAIL col_overlap_count got=%0d exp=2", count); end
  endtask

  task automatic test_reset_mid();
    drive_alloc(2'b11, 5'd1, 5'd2);
    tick();
    drive_alloc(2'b11, 5'd3, 5'd4);
    tick();
    drive_alloc(2'b01, 5'd5, 5'd0);
    tick(); idle();
    checks++; if (count !== 4'd7) begin failures++; $display("FAIL rmid_count7 got=%0d exp=7", count); end
    drive_wb(0, 4'hE, 32'hE0, 1'b0, 32'h0);
    drive_wb(1, 4'hF, 32'hF0, 1'b0, 32'h0);
    tick(); idle();
    tick();
    checks++; if (commit_valid !== 2'b11 || commit_data[0] !== 32'hE0 || commit_data[1] !== 32'hF0 || count !== 4'd5) begin failures++; $display("FAIL rmid_pre got=%b %h %h %0d exp=11 e0 f0 5", commit_valid, commit_data[0], commit_data[1], count); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (commit_valid !== 2'b00 || commit_data[0] !== 32'h0 || commit_data[1] !== 32'h0 || commit_rd[1] !== 5'd0) begin failures++; $display("FAIL rmid_outs got=%b %h %h %0d exp=00 0 0 0", commit_valid, commit_data[0], commit_data[1], commit_rd[1]); end
    checks++; if (count !== 4'd0 || alloc_ready !== 1'b1 || redirect !== 1'b0) begin failures++; $display("FAIL rmid_state got=%0d %b %b exp=0 1 0", count, alloc_ready, redirect); end
    tick();
    rst_n = 1'b1;
    drive_alloc(2'b01, 5'd9, 5'd0);
    #1;
    checks++; if (alloc_tag[0] !== 4'd0 || count !== 4'd0) begin failures++; $display("FAIL rmid_tag got=%0d/%0d exp=0/0", alloc_tag[0], count); end
    tick(); idle();
    checks++; if (count !== 4'd1) begin failures++; $display("FAIL rmid_alloc got=%0d exp=1", count); end
  endtask

  initial begin
    idle();
    test_reset();
    test_basic_ooo();
    test_full();
    test_stale_wrap();
    test_branch();
    test_collision_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
